// File: rtl/board_input_conditioner_pkg.sv
// Shared constants and types for the board input conditioner.
// Holds the clog2 helper and the reset stretcher state encoding.
package board_input_conditioner_pkg;

  typedef enum logic {
    RST_ASSERT  = 1'b0,
    RST_RELEASE = 1'b1
  } rst_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/board_input_conditioner_debounce_channel.sv
// One conditioned input: two-flop synchroniser, hold-time debounce counter,
// accepted level and registered one-cycle rise/fall pulses.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    s0_d    = din;
    s1_d    = s0_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any sample matching the accepted level discards progress toward a change.
    if (s1_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      fall_d  = level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/board_input_conditioner.sv
// Conditioning bank for asynchronous board switches/buttons, plus a stretched
// system reset driven by rst or by the debounced level of one channel.
module board_input_conditioner
  import board_input_conditioner_pkg::*;
#(
  parameter int                  CHANNELS        = 4,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = {CHANNELS{1'b0}},
  parameter int                  RST_CHANNEL     = 0,
  parameter int                  RST_STRETCH     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                sys_rst_out
);

  localparam int CNT_W  = clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SCNT_W = clog2(RST_STRETCH) + 1;

  generate
    if (RST_CHANNEL >= CHANNELS) begin : g_bad_rst_channel
      $error("RST_CHANNEL must be below CHANNELS");
    end
  endgenerate

  logic [CHANNELS-1:0] corrected;
  assign corrected = raw_in ^ ACTIVE_LOW_MASK;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_ch (
        .clk  (clk),
        .rst  (rst),
        .din  (corrected[i]),
        .level(level[i]),
        .rise (rise[i]),
        .fall (fall[i])
      );
    end
  endgenerate

  rst_state_e        state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              rst_req;

  assign rst_req = level[RST_CHANNEL];

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    if (rst_req) begin
      state_d = RST_ASSERT;
      scnt_d  = '0;
    end else if (state_q == RST_ASSERT) begin
      if (scnt_q == SCNT_W'(RST_STRETCH - 1)) begin
        state_d = RST_RELEASE;
        scnt_d  = '0;
      end else begin
        scnt_d = scnt_q + SCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_ASSERT;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // The request level is itself a flop, so ORing it in asserts the reset on
  // the same edge the channel is accepted without adding a glitch path.
  assign sys_rst_out = (state_q == RST_ASSERT) | rst_req;

endmodule
